// File: rtl/bounded_step_counter_pkg.sv
// Shared types and constants for the bounded step counter.
package bounded_step_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bounded_step_counter_next.sv
// Combinational next-count stage: adds or subtracts the step with one extra
// bit so that carry out of the top and borrow below zero are both visible,
// then reports whether the result left [lo, hi] and which bounds apply.
module bsc_next #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              up,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  next_val,
  output logic              out_of_range,
  output logic [WIDTH-1:0]  bound,
  output logic [WIDTH-1:0]  far_bound
);

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extended-width arithmetic and range test for the current direction
  always_comb begin
    step_ext = (WIDTH+1)'(step);
    sum      = {1'b0, count} + step_ext;
    diff     = {1'b0, count} - step_ext;
    if (up) begin
      next_val     = sum[WIDTH-1:0];
      out_of_range = (sum > {1'b0, hi});
      bound        = hi;
      far_bound    = lo;
    end else begin
      // diff MSB set means the subtraction went below zero
      next_val     = diff[WIDTH-1:0];
      out_of_range = diff[WIDTH] || (diff[WIDTH-1:0] < lo);
      bound        = lo;
      far_bound    = hi;
    end
  end

endmodule

// File: rtl/bounded_step_counter.sv
// Bounded up/down step counter with STOP, WRAP and BOUNCE boundary actions.
module bounded_step_counter
  import bounded_step_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned RESET_VAL = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dir_up,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic              err
);

  state_e            state, state_n;
  logic [WIDTH-1:0]  count_q, count_n;
  logic              dir_q, dir_n;
  mode_e             mode_q, mode_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic [WIDTH-1:0]  lo_q, lo_n;
  logic [WIDTH-1:0]  hi_q, hi_n;
  logic              done_q, done_n;
  logic              wrap_q, wrap_n;
  logic              err_q, err_n;

  logic [WIDTH-1:0]  next_val;
  logic              out_of_range;
  logic [WIDTH-1:0]  bound;
  logic [WIDTH-1:0]  far_bound;

  bsc_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .count        (count_q),
    .step         (step_q),
    .up           (dir_q),
    .lo           (lo_q),
    .hi           (hi_q),
    .next_val     (next_val),
    .out_of_range (out_of_range),
    .bound        (bound),
    .far_bound    (far_bound)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count_q <= WIDTH'(RESET_VAL);
      dir_q   <= 1'b0;
      mode_q  <= MODE_STOP;
      step_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      dir_q   <= dir_n;
      mode_q  <= mode_n;
      step_q  <= step_n;
      lo_q    <= lo_n;
      hi_q    <= hi_n;
      done_q  <= done_n;
      wrap_q  <= wrap_n;
      err_q   <= err_n;
    end
  end

  // Next-state, latch and pulse decisions; stop takes priority over boundary events
  always_comb begin
    state_n = state;
    count_n = count_q;
    dir_n   = dir_q;
    mode_n  = mode_q;
    step_n  = step_q;
    lo_n    = lo_q;
    hi_n    = hi_q;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            dir_n   = dir_up;
            mode_n  = mode_e'(mode);
            step_n  = step;
            lo_n    = lo;
            hi_n    = hi;
            count_n = dir_up ? lo : hi;
            state_n = ST_RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (!out_of_range) begin
          count_n = next_val;
        end else begin
          case (mode_q)
            MODE_WRAP: begin
              count_n = far_bound;
              wrap_n  = 1'b1;
            end
            MODE_BOUNCE: begin
              count_n = bound;
              dir_n   = ~dir_q;
              wrap_n  = 1'b1;
            end
            default: begin
              count_n = bound;
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign count = count_q;
  assign busy  = (state == ST_RUN);
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bounded_step_counter.sv
// Directed scoreboard bench for bounded_step_counter.
module tb_bounded_step_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir_up = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] step = 4'd0;
  logic [7:0] lo = 8'd0;
  logic [7:0] hi = 8'd0;
  logic [7:0] count;
  logic       busy, done, wrap, err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      name;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t sb[$];

  bounded_step_counter #(
    .WIDTH     (8),
    .STEP_W    (4),
    .RESET_VAL (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .stop   (stop),
    .dir_up (dir_up),
    .mode   (mode),
    .step   (step),
    .lo     (lo),
    .hi     (hi),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .wrap   (wrap),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of start/stop and queue the outputs expected after the edge
  task automatic cyc(input string name, input logic s, input logic p,
                     input logic [7:0] c, input logic b, input logic d,
                     input logic w, input logic e);
    exp_t x;
    start = s;
    stop  = p;
    x.name = name; x.count = c; x.busy = b; x.done = d; x.wrap = w; x.err = e;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic setup(input logic d, input logic [1:0] m, input logic [3:0] s,
                       input logic [7:0] l, input logic [7:0] h);
    dir_up = d; mode = m; step = s; lo = l; hi = h;
  endtask

  // Monitor: every edge with a queued expectation is compared shortly after it
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        vectors++;
        if ({count, busy, done, wrap, err} !== {x.count, x.busy, x.done, x.wrap, x.err}) begin
          miscompares++;
          $display("FAIL %s: got count=%0d busy=%b done=%b wrap=%b err=%b, want count=%0d busy=%b done=%b wrap=%b err=%b",
                   x.name, count, busy, done, wrap, err, x.count, x.busy, x.done, x.wrap, x.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    cyc("reset", 0, 0, 8'd5, 0, 0, 0, 0);
    cyc("reset", 1, 0, 8'd5, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("idle_after_reset", 0, 0, 8'd5, 0, 0, 0, 0);

    // STOP mode run 5..66; inputs disturbed mid-run, start in RUN ignored
    setup(1, 2'd0, 4'd1, 8'd5, 8'd66);
    cyc("stop_start", 1, 0, 8'd5, 1, 0, 0, 0);
    setup(0, 2'd1, 4'd7, 8'd0, 8'd200);
    for (int v = 6; v <= 66; v++)
      cyc("stop_run", (v == 30), 0, 8'(v), 1, 0, 0, 0);
    cyc("stop_done", 0, 0, 8'd66, 0, 1, 0, 0);
    cyc("stop_after", 0, 0, 8'd66, 0, 0, 0, 0);
    cyc("stop_in_idle", 0, 1, 8'd66, 0, 0, 0, 0);

    // Bad bounds
    setup(1, 2'd0, 4'd1, 8'd20, 8'd10);
    cyc("bad_bounds", 1, 0, 8'd66, 0, 0, 0, 1);
    cyc("bad_bounds_after", 0, 0, 8'd66, 0, 0, 0, 0);

    // WRAP; stop coincides with a wrap event
    setup(1, 2'd1, 4'd3, 8'd5, 8'd10);
    cyc("wrap_start", 1, 0, 8'd5, 1, 0, 0, 0);
    cyc("wrap_run", 0, 0, 8'd8, 1, 0, 0, 0);
    cyc("wrap_event", 0, 0, 8'd5, 1, 0, 1, 0);
    cyc("wrap_run", 0, 0, 8'd8, 1, 0, 0, 0);
    cyc("wrap_stop", 0, 1, 8'd8, 0, 0, 0, 0);

    // BOUNCE with borrow
    setup(0, 2'd2, 4'd2, 8'd0, 8'd3);
    cyc("bounce_start", 1, 0, 8'd3, 1, 0, 0, 0);
    cyc("bounce_run", 0, 0, 8'd1, 1, 0, 0, 0);
    cyc("bounce_borrow", 0, 0, 8'd0, 1, 0, 1, 0);
    cyc("bounce_run", 0, 0, 8'd2, 1, 0, 0, 0);
    cyc("bounce_top", 0, 0, 8'd3, 1, 0, 1, 0);
    cyc("bounce_run", 0, 0, 8'd1, 1, 0, 0, 0);
    cyc("bounce_stop", 0, 1, 8'd1, 0, 0, 0, 0);

    // Carry out of 8 bits
    setup(1, 2'd1, 4'd4, 8'd0, 8'd255);
    cyc("carry_start", 1, 0, 8'd0, 1, 0, 0, 0);
    for (int k = 1; k <= 63; k++)
      cyc("carry_run", 0, 0, 8'(4 * k), 1, 0, 0, 0);
    cyc("carry_wrap", 0, 0, 8'd0, 1, 0, 1, 0);
    cyc("carry_run", 0, 0, 8'd4, 1, 0, 0, 0);
    cyc("carry_stop", 0, 1, 8'd4, 0, 0, 0, 0);

    // Zero step holds with no pulses
    setup(1, 2'd0, 4'd0, 8'd10, 8'd20);
    cyc("zero_start", 1, 0, 8'd10, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      cyc("zero_hold", 0, 0, 8'd10, 1, 0, 0, 0);
    cyc("zero_stop", 0, 1, 8'd10, 0, 0, 0, 0);

    // lo == hi, BOUNCE then STOP
    setup(1, 2'd2, 4'd1, 8'd7, 8'd7);
    cyc("eq_bounce_start", 1, 0, 8'd7, 1, 0, 0, 0);
    cyc("eq_bounce", 0, 0, 8'd7, 1, 0, 1, 0);
    cyc("eq_bounce", 0, 0, 8'd7, 1, 0, 1, 0);
    cyc("eq_bounce_stop", 0, 1, 8'd7, 0, 0, 0, 0);
    setup(1, 2'd0, 4'd1, 8'd7, 8'd7);
    cyc("eq_stop_start", 1, 0, 8'd7, 1, 0, 0, 0);
    cyc("eq_stop_done", 0, 0, 8'd7, 0, 1, 0, 0);

    // Reserved mode acts as STOP
    setup(1, 2'd3, 4'd2, 8'd0, 8'd2);
    cyc("rsvd_start", 1, 0, 8'd0, 1, 0, 0, 0);
    cyc("rsvd_run", 0, 0, 8'd2, 1, 0, 0, 0);
    cyc("rsvd_done", 0, 0, 8'd2, 0, 1, 0, 0);

    // Stop on the cycle of a STOP-mode boundary: no done
    setup(1, 2'd0, 4'd2, 8'd0, 8'd4);
    cyc("stopprio_start", 1, 0, 8'd0, 1, 0, 0, 0);
    cyc("stopprio_run", 0, 0, 8'd2, 1, 0, 0, 0);
    cyc("stopprio_run", 0, 0, 8'd4, 1, 0, 0, 0);
    cyc("stopprio_stop", 0, 1, 8'd4, 0, 0, 0, 0);
    cyc("stopprio_idle", 0, 0, 8'd4, 0, 0, 0, 0);

    // Reset mid-run overrides start and stop
    setup(1, 2'd1, 4'd1, 8'd0, 8'd100);
    cyc("rstmid_start", 1, 0, 8'd0, 1, 0, 0, 0);
    cyc("rstmid_run", 0, 0, 8'd1, 1, 0, 0, 0);
    cyc("rstmid_run", 0, 0, 8'd2, 1, 0, 0, 0);
    rst_n = 1'b0;
    cyc("rstmid_reset", 1, 1, 8'd5, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("rstmid_release", 0, 0, 8'd5, 0, 0, 0, 0);

    #5;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bounded_step_counter.md
BOUNDED_STEP_COUNTER -- requirements
Module: bounded_step_counter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  - WIDTH, 8, count/bound width in bits.
  - STEP_W, 4, step input width in bits.
  - RESET_VAL, 5, count value after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  - clk  input  1  single clock; all state changes on rising edge.
  - rst_n  input  1  reset; synchronous, active-low.
  - start  input  1  launch a count run (taken in IDLE only).
  - stop  input  1  abort a run (taken in RUN only).
  - dir_up  input  1  initial direction: 1=up, 0=down.
  - mode  input  2  boundary action: 0=STOP, 1=WRAP, 2=BOUNCE, 3=reserved (treated as STOP).
  - step  input  STEP_W  unsigned increment per RUN cycle.
  - lo  input  WIDTH  unsigned lower bound, inclusive.
  - hi  input  WIDTH  unsigned upper bound, inclusive.
  - count  output  WIDTH  current count, registered.
  - busy  output  1  high while in RUN.
  - done  output  1  one-cycle pulse on a STOP-mode boundary hit.
  - wrap  output  1  one-cycle pulse on each WRAP or BOUNCE boundary event.
  - err  output  1  one-cycle pulse on start rejected because lo > hi.

Function
REQ-003 States SHALL be IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-004 In IDLE, start with lo <= hi SHALL do the following on that edge: latch dir_up, mode, step, lo and hi; load count with lo if dir_up, else hi; enter RUN.
REQ-005 In IDLE, start with lo > hi SHALL pulse err for one cycle; count SHALL hold and the state SHALL stay IDLE.
REQ-006 In RUN, each cycle SHALL compute next = count ± latched step in WIDTH+1 bits, so that carry and borrow are detected and never silently truncated.
REQ-007 If next is in [lo, hi], count SHALL take next.
REQ-008 When next is out of range, the latched mode SHALL select the action:
  - STOP: count SHALL clamp to the violated bound, done SHALL pulse, and the state SHALL return to IDLE.
  - WRAP: count SHALL take the opposite bound, wrap SHALL pulse, and the state SHALL stay RUN.
  - BOUNCE: count SHALL clamp to the violated bound, the direction SHALL invert, wrap SHALL pulse, and the state SHALL stay RUN.
REQ-009 With step = 0 in RUN, count SHALL hold with no pulses; the run continues until stop.
REQ-010 With lo == hi, any nonzero step SHALL be out of range on every cycle, and the mode action of REQ-008 SHALL apply.
REQ-011 stop in RUN SHALL return the state to IDLE with count held; no done or wrap pulse SHALL be emitted, even when a boundary event coincides (stop wins).
REQ-012 start in RUN and stop in IDLE SHALL be ignored.
REQ-013 Input changes to dir_up, mode, step, lo and hi during RUN SHALL have no effect until the next start.
REQ-014 done, wrap and err SHALL never be high for more than one consecutive cycle per event, and never simultaneously.

Reset
REQ-015 When rst_n is sampled low at a clk edge: count SHALL become RESET_VAL; busy, done, wrap and err SHALL be 0; the state SHALL be IDLE; latched fields SHALL be cleared.
REQ-016 Reset SHALL override start and stop in the same cycle, including mid-run; the first cycle after release SHALL be IDLE.

Structure
REQ-017 A shared package SHALL hold the mode encoding enum (STOP, WRAP, BOUNCE), the state enum (IDLE, RUN), and a default-width constant.
REQ-018 One combinational sub-module, bsc_next, SHALL compute the following from count, step, direction, lo and hi: the next value, the out-of-range flag, and the bound selected.

Verification
REQ-019 The bench SHALL cover at least the following directed scenarios:
  - STOP: WIDTH=8, lo=5, hi=66, step=1, up, STOP -> count=5 after start, then 6..66 over 61 cycles; next cycle count holds at 66, done pulses once, busy drops.
  - WRAP: lo=5, hi=10, step=3, up, WRAP -> 5, 8, 5 (wrap pulse), 8, ...; busy stays 1 until stop.
  - BOUNCE with borrow: lo=0, hi=3, step=2, down, BOUNCE -> 3, 1, 0 (wrap, dir up), 2, 3 (wrap, dir down), 1.
  - Carry boundary: lo=0, hi=255, step=4, up, WRAP, count reaches 252 -> next 256 detected, count=0, wrap pulse.
  - Bad bounds: lo=20, hi=10, start -> err pulses once, busy=0, count unchanged.
  - Stop and reset priority: stop asserted on the cycle of a STOP-mode boundary -> no done, count holds; rst_n low mid-run -> count=5, IDLE on the next cycle.
